// File: rtl/data_mem_ctrl_if.sv
// Signal bundle between the pipeline/backing memory and the data memory controller.
// The slave modport is the controller's view; the master modport is the environment's view.
interface data_mem_ctrl_if;
  logic [2:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSY_WAIT;
  logic        MISALIGN;
  logic        TIMEOUT_ERR;
  logic [29:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_BYTE_EN;
  logic        MEM_RD;
  logic        MEM_WR;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;

  modport slave (
    input  MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA, MEM_RDATA, MEM_ACK,
    output READ_DATA, BUSY_WAIT, MISALIGN, TIMEOUT_ERR, MEM_ADDR, MEM_WDATA,
           MEM_BYTE_EN, MEM_RD, MEM_WR
  );

  modport master (
    output MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA, MEM_RDATA, MEM_ACK,
    input  READ_DATA, BUSY_WAIT, MISALIGN, TIMEOUT_ERR, MEM_ADDR, MEM_WDATA,
           MEM_BYTE_EN, MEM_RD, MEM_WR
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller: stalls the pipeline, issues one aligned load/store to a
// handshaked backing memory, aligns/extends load data, and flags misalign/timeout.
module data_mem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RESET,
  data_mem_ctrl_if.slave   bus,
  output logic [1:0]       state_o
);
  // Handshake: a request is held on MEM_READ/MEM_WRITE while BUSY_WAIT=1; the memory
  // strobe (MEM_RD/MEM_WR) stays high until MEM_ACK in the same cycle as MEM_RDATA.
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_e;

  localparam logic [2:0] LD_LB = 3'd1, LD_LH = 3'd2, LD_LW = 3'd3, LD_LBU = 3'd4, LD_LHU = 3'd5;
  localparam logic [2:0] ST_SB = 3'd1, ST_SH = 3'd2, ST_SW = 3'd3;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  rcode_q, rcode_d;
  logic [2:0]  wcode_q, wcode_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;

  logic [2:0]  rd_code, wr_code;
  logic        req_valid, misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  // Undefined codes behave as no-op; a store wins over a simultaneous load.
  always_comb begin
    wr_code = (bus.MEM_WRITE <= ST_SW) ? bus.MEM_WRITE : 3'd0;
    rd_code = (bus.MEM_READ <= LD_LHU) ? bus.MEM_READ : 3'd0;
    if (wr_code != 3'd0) rd_code = 3'd0;
    req_valid  = (rd_code != 3'd0) || (wr_code != 3'd0);
    misaligned = (((rd_code == LD_LH) || (rd_code == LD_LHU) || (wr_code == ST_SH)) && bus.ADDRESS[0])
              || (((rd_code == LD_LW) || (wr_code == ST_SW)) && (bus.ADDRESS[1:0] != 2'b00));
  end

  always_comb begin
    ld_byte  = bus.MEM_RDATA[{addr_q[1:0], 3'b000} +: 8];
    ld_half  = addr_q[1] ? bus.MEM_RDATA[31:16] : bus.MEM_RDATA[15:0];
    ld_value = bus.MEM_RDATA;
    case (rcode_q)
      LD_LB:   ld_value = {{24{ld_byte[7]}}, ld_byte};
      LD_LH:   ld_value = {{16{ld_half[15]}}, ld_half};
      LD_LBU:  ld_value = {24'd0, ld_byte};
      LD_LHU:  ld_value = {16'd0, ld_half};
      default: ld_value = bus.MEM_RDATA;
    endcase
    st_be    = 4'b1111;
    st_wdata = wdata_q;
    case (wcode_q)
      ST_SB: begin
        st_be    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{wdata_q[7:0]}};
      end
      ST_SH: begin
        st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rcode_d         = rcode_q;
    wcode_d         = wcode_q;
    wait_d          = wait_q;
    rdata_d         = rdata_q;
    misalign_d      = 1'b0;
    timeout_d       = 1'b0;
    bus.BUSY_WAIT   = 1'b0;
    bus.MEM_RD      = 1'b0;
    bus.MEM_WR      = 1'b0;
    bus.MEM_BYTE_EN = 4'b0000;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          bus.BUSY_WAIT = 1'b1;
          addr_d        = bus.ADDRESS;
          wdata_d       = bus.WRITE_DATA;
          rcode_d       = rd_code;
          wcode_d       = wr_code;
          wait_d        = 8'd0;
          if (misaligned) begin
            misalign_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = (wr_code != 3'd0) ? WRITE : READ;
          end
        end
      end
      READ, WRITE: begin
        bus.BUSY_WAIT   = 1'b1;
        bus.MEM_RD      = (state_q == READ);
        bus.MEM_WR      = (state_q == WRITE);
        bus.MEM_BYTE_EN = (state_q == WRITE) ? st_be : 4'b0000;
        if (bus.MEM_ACK) begin
          if (state_q == READ) rdata_d = ld_value;
          state_d = DONE;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rcode_q    <= 3'd0;
      wcode_q    <= 3'd0;
      wait_q     <= 8'd0;
      rdata_q    <= 32'd0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rcode_q    <= rcode_d;
      wcode_q    <= wcode_d;
      wait_q     <= wait_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.READ_DATA   = rdata_q;
  assign bus.MISALIGN    = misalign_q;
  assign bus.TIMEOUT_ERR = timeout_q;
  assign bus.MEM_ADDR    = ((state_q == READ) || (state_q == WRITE)) ? addr_q[31:2] : bus.ADDRESS[31:2];
  assign bus.MEM_WDATA   = st_wdata;
  assign state_o         = state_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: directed scenarios plus randomized loads, with
// expected load results queued at stimulus time and popped when the access completes.
module tb_data_mem_ctrl;
  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] state_o;

  data_mem_ctrl_if bus();

  data_mem_ctrl #(.TIMEOUT(255)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  logic [31:0] exp_v;

  int          obs_busy, obs_rd, obs_wr, obs_both, obs_mis, obs_to;
  bit          obs_done;
  logic [31:0] obs_rdata, obs_wd;
  logic [3:0]  obs_be, obs_be_idle;
  logic [29:0] obs_addr;

  function automatic logic [31:0] exp_load(input logic [2:0] code, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a[1:0], 3'b000});
    h = 16'(w >> {a[1], 4'b0000});
    case (code)
      3'd1:    return {{24{b[7]}}, b};
      3'd2:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // ack_delay: number of strobe cycles before MEM_ACK; negative means never.
  task automatic run_access(input logic [2:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int ack_delay);
    int mcyc;
    bit done;
    obs_busy = 0; obs_rd = 0; obs_wr = 0; obs_both = 0; obs_mis = 0; obs_to = 0;
    obs_done = 0; obs_rdata = '0; obs_wd = '0; obs_be = '0; obs_addr = '0; obs_be_idle = '0;
    mcyc = 0; done = 0;
    @(negedge CLK);
    bus.MEM_READ = rd; bus.MEM_WRITE = wr; bus.ADDRESS = addr;
    bus.WRITE_DATA = wdata; bus.MEM_RDATA = rdata; bus.MEM_ACK = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      #1;
      if (bus.MEM_RD && bus.MEM_WR) obs_both++;
      if (bus.MEM_RD) obs_rd++;
      if (bus.MEM_WR) begin
        if (obs_wr == 0) begin
          obs_be = bus.MEM_BYTE_EN; obs_wd = bus.MEM_WDATA; obs_addr = bus.MEM_ADDR;
        end
        obs_wr++;
      end
      if (bus.MISALIGN) obs_mis++;
      if (bus.TIMEOUT_ERR) obs_to++;
      if (bus.BUSY_WAIT) obs_busy++;
      else begin
        done = 1; obs_done = 1; obs_rdata = bus.READ_DATA;
        bus.MEM_READ = 3'd0; bus.MEM_WRITE = 3'd0;
      end
      if ((bus.MEM_RD || bus.MEM_WR) && ack_delay >= 0 && mcyc == ack_delay) bus.MEM_ACK = 1'b1;
      if (bus.MEM_RD || bus.MEM_WR) mcyc++;
      @(negedge CLK);
      bus.MEM_ACK = 1'b0;
    end
    #1;
    if (bus.MISALIGN) obs_mis++;
    if (bus.TIMEOUT_ERR) obs_to++;
    if (bus.BUSY_WAIT) obs_busy++;
    if (bus.MEM_RD) obs_rd++;
    if (bus.MEM_WR) obs_wr++;
    obs_be_idle = bus.MEM_BYTE_EN;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.MEM_READ = 3'd0; bus.MEM_WRITE = 3'd0; bus.ADDRESS = '0; bus.WRITE_DATA = '0;
    bus.MEM_RDATA = '0; bus.MEM_ACK = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    total++; if (bus.READ_DATA !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.READ_DATA); end
    total++; if (bus.BUSY_WAIT !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY_WAIT); end
    total++; if (bus.MISALIGN !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", bus.MISALIGN); end
    total++; if (bus.TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", bus.TIMEOUT_ERR); end
    total++; if ({bus.MEM_RD, bus.MEM_WR} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {bus.MEM_RD, bus.MEM_WR}); end
    total++; if (bus.MEM_BYTE_EN !== 4'b0000) begin bad++; $display("FAIL reset_be got=%b exp=0000", bus.MEM_BYTE_EN); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    @(negedge CLK);
    RESET = 1'b0;
    last_rd = 32'd0;
  endtask

  task automatic test_lb();
    exp_q.push_back(exp_load(3'd1, 32'h1003, 32'h80AB_CDEF));
    run_access(3'd1, 3'd0, 32'h0000_1003, 32'h0, 32'h80AB_CDEF, 3);
    exp_v = exp_q.pop_front(); last_rd = exp_v;
    total++; if (obs_done !== 1'b1) begin bad++; $display("FAIL lb_done got=%b exp=1", obs_done); end
    total++; if (obs_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_const got=%h exp=ffffff80", obs_rdata); end
    total++; if (obs_rdata !== exp_v) begin bad++; $display("FAIL lb_rdata got=%h exp=%h", obs_rdata, exp_v); end
    total++; if (obs_busy !== 5) begin bad++; $display("FAIL lb_busy got=%0d exp=5", obs_busy); end
    total++; if (obs_rd !== 4 || obs_wr !== 0) begin bad++; $display("FAIL lb_strobes got=%0d/%0d exp=4/0", obs_rd, obs_wr); end
  endtask

  task automatic test_lhu();
    exp_q.push_back(exp_load(3'd5, 32'h2002, 32'h8001_1234));
    run_access(3'd5, 3'd0, 32'h0000_2002, 32'h0, 32'h8001_1234, 0);
    exp_v = exp_q.pop_front(); last_rd = exp_v;
    total++; if (obs_rdata !== 32'h0000_8001) begin bad++; $display("FAIL lhu_rdata got=%h exp=00008001", obs_rdata); end
    total++; if (obs_busy !== 2) begin bad++; $display("FAIL lhu_latency got=%0d exp=2", obs_busy); end
  endtask

  task automatic test_sh();
    exp_q.push_back(last_rd);
    run_access(3'd0, 3'd2, 32'h0000_0006, 32'hDEAD_BEEF, 32'h5555_5555, 2);
    exp_v = exp_q.pop_front();
    total++; if (obs_addr !== 30'd1) begin bad++; $display("FAIL sh_addr got=%h exp=1", obs_addr); end
    total++; if (obs_be !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b exp=1100", obs_be); end
    total++; if (obs_wd !== 32'hBEEF_BEEF) begin bad++; $display("FAIL sh_wdata got=%h exp=beefbeef", obs_wd); end
    total++; if (obs_wr !== 3 || obs_rd !== 0) begin bad++; $display("FAIL sh_strobes got=%0d/%0d exp=3/0", obs_wr, obs_rd); end
    total++; if (obs_rdata !== exp_v) begin bad++; $display("FAIL sh_rdata_kept got=%h exp=%h", obs_rdata, exp_v); end
    total++; if (obs_be_idle !== 4'b0000) begin bad++; $display("FAIL sh_be_idle got=%b exp=0000", obs_be_idle); end
  endtask

  task automatic test_misalign();
    logic [2:0]  rds[3] = '{3'd3, 3'd2, 3'd0};
    logic [2:0]  wrs[3] = '{3'd0, 3'd0, 3'd2};
    logic [31:0] ads[3] = '{32'h1, 32'h11, 32'h3};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(last_rd);
      run_access(rds[i], wrs[i], ads[i], 32'hCAFE_F00D, 32'h1234_5678, 0);
      exp_v = exp_q.pop_front();
      total++; if (obs_rd !== 0 || obs_wr !== 0) begin bad++; $display("FAIL mis%0d_strobes got=%0d/%0d exp=0/0", i, obs_rd, obs_wr); end
      total++; if (obs_mis !== 1) begin bad++; $display("FAIL mis%0d_pulse got=%0d exp=1", i, obs_mis); end
      total++; if (obs_busy !== 1) begin bad++; $display("FAIL mis%0d_busy got=%0d exp=1", i, obs_busy); end
      total++; if (obs_rdata !== exp_v) begin bad++; $display("FAIL mis%0d_rdata got=%h exp=%h", i, obs_rdata, exp_v); end
    end
  endtask

  task automatic test_timeout();
    exp_q.push_back(last_rd);
    run_access(3'd0, 3'd3, 32'h0000_0100, 32'h0BAD_F00D, 32'h0, -1);
    exp_v = exp_q.pop_front();
    total++; if (obs_done !== 1'b1) begin bad++; $display("FAIL to_done got=%b exp=1", obs_done); end
    total++; if (obs_wr !== 255) begin bad++; $display("FAIL to_wr_cycles got=%0d exp=255", obs_wr); end
    total++; if (obs_to !== 1) begin bad++; $display("FAIL to_pulse got=%0d exp=1", obs_to); end
    total++; if (obs_busy !== 256) begin bad++; $display("FAIL to_busy got=%0d exp=256", obs_busy); end
    total++; if (obs_rdata !== exp_v) begin bad++; $display("FAIL to_rdata got=%h exp=%h", obs_rdata, exp_v); end
  endtask

  task automatic test_codes();
    // Store wins over load issued in the same cycle.
    run_access(3'd3, 3'd1, 32'h0000_0202, 32'h0000_00A5, 32'h0, 1);
    total++; if (obs_rd !== 0 || obs_wr !== 2) begin bad++; $display("FAIL prio_strobes got=%0d/%0d exp=0/2", obs_rd, obs_wr); end
    total++; if (obs_be !== 4'b0100) begin bad++; $display("FAIL prio_be got=%b exp=0100", obs_be); end
    total++; if (obs_wd !== 32'hA5A5_A5A5) begin bad++; $display("FAIL prio_wdata got=%h exp=a5a5a5a5", obs_wd); end
    // Undefined codes are no-ops.
    run_access(3'd6, 3'd4, 32'h0000_0000, 32'h0, 32'h0, 0);
    total++; if (obs_busy !== 0 || obs_rd !== 0 || obs_wr !== 0) begin bad++; $display("FAIL badcode got=%0d/%0d/%0d exp=0/0/0", obs_busy, obs_rd, obs_wr); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  code;
    logic [31:0] addr, word;
    int          dly;
    for (int i = 0; i < 10; i++) begin
      code = 3'($urandom_range(1, 5));
      addr = $urandom;
      if (code == 3'd3) addr[1:0] = 2'b00;
      else if (code == 3'd2 || code == 3'd5) addr[0] = 1'b0;
      word = $urandom;
      dly  = $urandom_range(0, 4);
      exp_q.push_back(exp_load(code, addr, word));
      run_access(code, 3'd0, addr, 32'h0, word, dly);
      exp_v = exp_q.pop_front(); last_rd = exp_v;
      total++; if (obs_rdata !== exp_v) begin bad++; $display("FAIL b2b%0d_rdata code=%0d got=%h exp=%h", i, code, obs_rdata, exp_v); end
      total++; if (obs_busy !== dly + 2 || obs_both !== 0) begin bad++; $display("FAIL b2b%0d_timing got=%0d/%0d exp=%0d/0", i, obs_busy, obs_both, dly + 2); end
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge CLK);
    bus.MEM_READ = 3'd3; bus.ADDRESS = 32'h40; bus.MEM_RDATA = 32'h1234_5678; bus.MEM_ACK = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    total++; if (bus.MEM_RD !== 1'b1) begin bad++; $display("FAIL rst_mid_inread got=%b exp=1", bus.MEM_RD); end
    RESET = 1'b1; bus.MEM_READ = 3'd0;
    @(negedge CLK);
    RESET = 1'b0; bus.MEM_ACK = 1'b1;
    #1;
    total++; if ({bus.BUSY_WAIT, bus.MEM_RD, bus.MEM_WR} !== 3'b000) begin bad++; $display("FAIL rst_mid_outs got=%b exp=000", {bus.BUSY_WAIT, bus.MEM_RD, bus.MEM_WR}); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rst_mid_state got=%0d exp=0", state_o); end
    @(negedge CLK);
    bus.MEM_ACK = 1'b0;
    #1;
    total++; if (bus.READ_DATA !== 32'd0) begin bad++; $display("FAIL rst_mid_lateack got=%h exp=0", bus.READ_DATA); end
    total++; if (state_o !== 2'd0 || bus.BUSY_WAIT !== 1'b0) begin bad++; $display("FAIL rst_mid_idle got=%0d/%b exp=0/0", state_o, bus.BUSY_WAIT); end
    last_rd = 32'd0;
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lhu();
    test_sh();
    test_misalign();
    test_timeout();
    test_codes();
    test_back_to_back();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
